hc161: RTL and testbench
========================

HC161 -- requirements
Module: hc161

Interface
REQ-001 Parameters: none; counter width comes from the package constant HC161_W = 4.
REQ-002 CP  input  1  clock; all synchronous state changes occur on the rising edge.
REQ-003 MR_n  input  1  master reset, asynchronous, active-low.
REQ-004 Q  output  4  counter state, registered.
REQ-005 TC  output  1  terminal count, combinational.
REQ-006 CEP_n  input  1  count enable (parallel), active-low.
REQ-007 CET_n  input  1  count enable (trickle), active-low.
REQ-008 PE_n  input  1  parallel load enable, synchronous, active-low.
REQ-009 D  input  4  parallel load data.
REQ-010 Positional port order SHALL be Q, TC, MR_n, CP, CEP_n, CET_n, PE_n, D.

Function
REQ-011 Per rising CP edge with MR_n=1, priority SHALL be: load > count > hold.
REQ-012 Load: PE_n=0 -> Q <= D, regardless of CEP_n and CET_n.
REQ-013 Count: PE_n=1, CEP_n=0, CET_n=0 -> Q <= Q+1 modulo 16, so 4'hF wraps to 4'h0.
REQ-014 Hold: PE_n=1 and (CEP_n=1 or CET_n=1) -> Q unchanged.
REQ-015 Latency: Q SHALL reflect a load or increment one edge after sampling, with no extra pipeline stage.
REQ-016 TC SHALL be 1 when Q==4'hF and the TC gating term (REQ-022/023) is true; otherwise 0. TC has no register delay relative to Q, CET_n.
REQ-017 Loading 4'hF with CET_n=0 SHALL assert TC in the cycle after the load edge.
REQ-018 All inputs SHALL be sampled only at the CP edge, except MR_n.

Reset
REQ-019 MR_n=0 SHALL force Q=4'h0 immediately, independent of CP; TC follows to 0.
REQ-020 While MR_n=0, loads and counts SHALL be ignored.
REQ-021 On MR_n deassertion, the first rising CP edge with MR_n=1 SHALL operate normally. A reset mid-count SHALL discard the current count.

Configuration
REQ-022 Macro HC161_TC_GATE_EN defined (default build): TC = (Q==4'hF) AND (CET_n==0), giving standard 74HC161 cascade behaviour.
REQ-023 Macro HC161_TC_GATE_EN undefined: TC = (Q==4'hF), ignoring CET_n; all other behaviour is identical.

Structure
REQ-024 Package hc161_pkg SHALL hold HC161_W=4, HC161_MAX=4'hF, and the type cnt_t (HC161_W-bit logic).
REQ-025 One sub-module hc161_next is permitted: pure combinational next-state logic (inputs Q, D, PE_n, CEP_n, CET_n; output next Q). The top level holds the register and the TC logic.

Verification
REQ-026 Reset: Q=4'h5, MR_n=0 mid-cycle -> Q=4'h0 before the next CP edge; TC=0.
REQ-027 Load: PE_n=0, D=4'hA, CEP_n=CET_n=1 for one edge -> Q=4'hA.
REQ-028 Count: from Q=4'hA, CEP_n=CET_n=0, PE_n=1 for 4 edges -> Q=4'hB, 4'hC, 4'hD, 4'hE.
REQ-029 Wrap and TC: load 4'hE, count with CET_n=0 -> Q=4'hF with TC=1, next edge Q=4'h0 with TC=0.
REQ-030 Hold: Q=4'hF, CEP_n=1, CET_n=0 for 2 edges -> Q stays 4'hF, TC=1. Then CET_n=1 -> TC=0 with HC161_TC_GATE_EN defined, TC=1 without it.
REQ-031 Priority: PE_n=0, D=4'h3, CEP_n=CET_n=0 -> Q=4'h3, with no increment.

Source files
------------

// File: rtl/hc161_pkg.sv
// hc161_pkg -- shared constants and types for the hc161 4-bit counter.
//
// Contents:
//   HC161_W    counter width (4)
//   cnt_t      HC161_W-bit counter value type
//   HC161_MAX  terminal count value (4'hF)
//   is_max()   true when a counter value equals HC161_MAX
package hc161_pkg;

    localparam int unsigned HC161_W = 4;

    typedef logic [HC161_W-1:0] cnt_t;

    localparam cnt_t HC161_MAX = 4'hF;

    function automatic logic is_max(input cnt_t value);
        return value == HC161_MAX;
    endfunction

endpackage

// File: rtl/hc161_next.sv
// hc161_next -- combinational next-state logic for the hc161 counter.
//
// Ports:
//   Q       in   current counter state
//   D       in   parallel load data
//   PE_n    in   parallel load enable, active-low (highest priority)
//   CEP_n   in   count enable (parallel), active-low
//   CET_n   in   count enable (trickle), active-low
//   Q_next  out  value the register takes on the next rising clock edge
module hc161_next
    import hc161_pkg::*;
(
    input  logic [HC161_W-1:0] Q,
    input  logic [HC161_W-1:0] D,
    input  logic               PE_n,
    input  logic               CEP_n,
    input  logic               CET_n,
    output logic [HC161_W-1:0] Q_next
);

    // Priority: load, then count (both enables low), otherwise hold.
    // The increment wraps naturally at the counter width.
    always_comb begin
        Q_next = Q;
        if (!PE_n) begin
            Q_next = D;
        end else if (!CEP_n && !CET_n) begin
            Q_next = Q + cnt_t'(1);
        end
    end

endmodule

// File: rtl/hc161.sv
// hc161 -- 4-bit synchronous binary counter with parallel load, modelled on
// the 74HC161.
//
// Ports:
//   Q      out  counter state (registered)
//   TC     out  terminal count (combinational from Q and CET_n)
//   MR_n   in   master reset, asynchronous, active-low
//   CP     in   clock, rising edge
//   CEP_n  in   count enable (parallel), active-low
//   CET_n  in   count enable (trickle), active-low
//   PE_n   in   parallel load enable, synchronous, active-low
//   D      in   parallel load data
//
// Configuration macro:
//   HC161_TC_GATE_EN  defined:   TC = (Q == 4'hF) && !CET_n  (cascade behaviour)
//                     undefined: TC = (Q == 4'hF)
module hc161
    import hc161_pkg::*;
(
    output logic [HC161_W-1:0] Q,
    output logic               TC,
    input  logic               MR_n,
    input  logic               CP,
    input  logic               CEP_n,
    input  logic               CET_n,
    input  logic               PE_n,
    input  logic [HC161_W-1:0] D
);

    cnt_t q_q;
    cnt_t q_d;

    hc161_next u_next (
        .Q      (q_q),
        .D      (D),
        .PE_n   (PE_n),
        .CEP_n  (CEP_n),
        .CET_n  (CET_n),
        .Q_next (q_d)
    );

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

    // TC is combinational so a cascaded stage sees it in the same cycle.
    always_comb begin
`ifdef HC161_TC_GATE_EN
        TC = is_max(q_q) && !CET_n;
`else
        TC = is_max(q_q);
`endif
    end

endmodule

// File: tb/tb_hc161.sv
// tb_hc161 -- scoreboard bench for hc161: directed sequence followed by
// randomized stimulus, expected {Q, TC} queued per clock edge and checked by
// an independent monitor.
module tb_hc161;
    import hc161_pkg::*;

    logic [3:0] Q;
    logic       TC;
    logic       MR_n;
    logic       CP;
    logic       CEP_n;
    logic       CET_n;
    logic       PE_n;
    logic [3:0] D;

    hc161 dut (
        .Q     (Q),
        .TC    (TC),
        .MR_n  (MR_n),
        .CP    (CP),
        .CEP_n (CEP_n),
        .CET_n (CET_n),
        .PE_n  (PE_n),
        .D     (D)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tc;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: an integer counter 0..15.
    int model_q = 0;

    function automatic logic model_tc(input int q, input logic cet_n);
`ifdef HC161_TC_GATE_EN
        return (q == 15) && !cet_n;
`else
        return q == 15;
`endif
    endfunction

    task automatic check(input string name, input logic [3:0] act_q, input logic act_tc,
                         input logic [3:0] req_q, input logic req_tc);
        checks++;
        if (act_q !== req_q || act_tc !== req_tc) begin
            errors++;
            $display("FAIL %s: got Q=%h TC=%b, expected Q=%h TC=%b",
                     name, act_q, act_tc, req_q, req_tc);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected
    // state after the following rising edge.
    task automatic cycle(input string name, input logic mr_n, input logic pe_n,
                         input logic cep_n, input logic cet_n, input logic [3:0] d);
        exp_t e;
        logic was_running;
        @(negedge CP);
        was_running = MR_n;
        MR_n  = mr_n;
        PE_n  = pe_n;
        CEP_n = cep_n;
        CET_n = cet_n;
        D     = d;
        if (!mr_n) begin
            model_q = 0;
        end else if (!pe_n) begin
            model_q = int'(d);
        end else if (!cep_n && !cet_n) begin
            model_q = (model_q + 1) % 16;
        end
        e.name = name;
        e.q    = 4'(model_q);
        e.tc   = model_tc(model_q, cet_n);
        exp_q.push_back(e);
        // Reset acts immediately, without waiting for a clock edge.
        if (!mr_n && was_running) begin
            #1;
            check({name, "_async"}, Q, TC, 4'h0, 1'b0);
        end
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CP);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, Q, TC, e.q, e.tc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        MR_n = 1'b0; PE_n = 1'b1; CEP_n = 1'b1; CET_n = 1'b1; D = 4'h0;
        #1;
        check("reset_init", Q, TC, 4'h0, 1'b0);

        // Reset held: loads and counts are ignored.
        cycle("rst_hold_load",  1'b0, 1'b0, 1'b0, 1'b0, 4'h9);
        cycle("rst_hold_count", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        // Load 5, then reset mid-cycle.
        cycle("load5",     1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
        cycle("reset_mid", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        // Load A, then count four edges.
        cycle("load_a", 1'b1, 1'b0, 1'b1, 1'b1, 4'hA);
        for (int i = 0; i < 4; i++) cycle("count_from_a", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Wrap through F with TC.
        cycle("load_e", 1'b1, 1'b0, 1'b1, 1'b1, 4'hE);
        cycle("count_to_f", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        cycle("wrap_to_0",  1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Load F with CET_n low, hold, then raise CET_n.
        cycle("load_f_tc", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
        for (int i = 0; i < 2; i++) cycle("hold_f", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        cycle("hold_f_cet_hi", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        cycle("hold_cep_lo_cet_hi", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);

        // Load beats count.
        cycle("priority_load", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);

        // Randomized traffic with occasional resets; count-heavy to hit wraps.
        for (int i = 0; i < 400; i++) begin
            logic mr_n;
            logic pe_n;
            mr_n = ($urandom_range(0, 24) != 0);
            pe_n = ($urandom_range(0, 7) != 0);
            cycle("random", mr_n, pe_n, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        // Let the monitor drain the final expectation.
        @(negedge CP);
        @(negedge CP);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
